// File: rtl/jt49_cmdseq_pkg.sv
// jt49_cmdseq_pkg
//   Shared constants for the jt49 command sequencer: the command word width,
//   the two non-write opcodes, and the sequencer state encoding.
//   Every other opcode (0x0-0xD) is a register write to jt49 register = op.
package jt49_cmdseq_pkg;

    localparam int CMD_W = 12;  // {op[11:8], data[7:0]}

    localparam logic [3:0] OP_END  = 4'hE;
    localparam logic [3:0] OP_WAIT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/jt49_cmdseq_fifo.sv
// jt49_cmdseq_fifo
//   Single-clock command FIFO, depth 2**AW, with a show-ahead head word.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     push, din       write din at the tail when not full
//     pop             drop the head word when not empty
//     flush           synchronous clear; wins over push and pop
//     dout            head word (valid while !empty)
//     full, level     registered, reflect post-cycle occupancy
//     empty           derived from the registered level
module jt49_cmdseq_fifo
    import jt49_cmdseq_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [CMD_W-1:0] din,
    input  logic             pop,
    input  logic             flush,
    output logic [CMD_W-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam int DEPTH = 2 ** AW;

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;
    logic [AW:0]      level_nxt;

    assign wr_en = push && !full && !flush;
    assign rd_en = pop && !empty && !flush;
    assign empty = (level == '0);
    assign dout  = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        if (wr_en && !rd_en) level_nxt = level + (AW+1)'(1);
        if (rd_en && !wr_en) level_nxt = level - (AW+1)'(1);
    end

    // Storage carries no reset; only the pointers and level define contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            full  <= (level_nxt == (AW+1)'(DEPTH));
        end
    end

endmodule

// File: rtl/jt49_cmdseq.sv
// jt49_cmdseq
//   Register-write sequencer feeding the jt49 write port. The host queues
//   12-bit commands {op,data}; they are replayed on cen ticks:
//     op 0x0-0xD  write data to jt49 register op (one-clk wr_n/cs_n pulse)
//     op 0xF      wait (data << WAIT_SHIFT) + 1 cen ticks
//     op 0xE      stop; stays in DONE until flush or reset
//   Ports:
//     clk, rst_n, cen       clock, async active-low reset, PSG clock enable
//     push, cmd, flush      host side: queue a word / clear everything
//     full, level, ovf      FIFO status; ovf is sticky on a dropped push
//     busy, done            sequencer status
//     addr, dout, wr_n, cs_n jt49 write port
//     wrcnt                 write pulse counter (only with JT49_CMDSEQ_WRCNT_EN)
//   Build option: define JT49_CMDSEQ_WRCNT_EN to add the wrcnt output.
module jt49_cmdseq
    import jt49_cmdseq_pkg::*;
#(
    parameter int AW         = 4,
    parameter int WAIT_SHIFT = 8,
    parameter int CW         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             push,
    input  logic [CMD_W-1:0] cmd,
    input  logic             flush,
    output logic             full,
    output logic [AW:0]      level,
    output logic             ovf,
    output logic             busy,
    output logic             done,
    output logic [3:0]       addr,
    output logic [7:0]       dout,
    output logic             wr_n,
    output logic             cs_n
`ifdef JT49_CMDSEQ_WRCNT_EN
    ,
    output logic [15:0]      wrcnt
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic             pop_en;
    logic             empty;
    logic [CMD_W-1:0] head;
    logic [3:0]       head_op;
    logic [7:0]       head_data;
    logic [CW-1:0]    cnt;

    assign head_op   = head[11:8];
    assign head_data = head[7:0];

    jt49_cmdseq_fifo #(.AW(AW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (cmd),
        .pop   (pop_en),
        .flush (flush),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        state_nxt = state;
        pop_en    = 1'b0;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cen && !empty) begin
                        pop_en = 1'b1;
                        if (head_op == OP_END)       state_nxt = ST_DONE;
                        else if (head_op == OP_WAIT) state_nxt = ST_WAIT;
                        else                         state_nxt = ST_ISSUE;
                    end
                end
                // The write pulse lasts one clk regardless of cen.
                ST_ISSUE: state_nxt = ST_IDLE;
                ST_WAIT: begin
                    if (cen && cnt == '0) state_nxt = ST_IDLE;
                end
                ST_DONE: state_nxt = ST_DONE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ovf   <= 1'b0;
            addr  <= '0;
            dout  <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                cnt <= '0;
                ovf <= 1'b0;
            end else begin
                // Judged on the registered full flag, so a same-cycle pop
                // does not rescue the word.
                if (push && full) ovf <= 1'b1;
                if (pop_en && head_op == OP_WAIT)
                    cnt <= CW'(head_data) << WAIT_SHIFT;
                else if (state == ST_WAIT && cen && cnt != '0)
                    cnt <= cnt - CW'(1);
                if (pop_en && head_op != OP_WAIT && head_op != OP_END) begin
                    addr <= head_op;
                    dout <= head_data;
                end
            end
        end
    end

    // Strobes decode straight from the state register, so an asynchronous
    // reset cuts a pulse short immediately.
    assign wr_n = (state != ST_ISSUE);
    assign cs_n = (state != ST_ISSUE);
    assign done = (state == ST_DONE);
    assign busy = (state != ST_IDLE) || !empty;

`ifdef JT49_CMDSEQ_WRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                wrcnt <= '0;
        else if (flush)            wrcnt <= '0;
        else if (state == ST_ISSUE) wrcnt <= wrcnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_jt49_cmdseq.sv
// tb_jt49_cmdseq
//   Self-checking bench for jt49_cmdseq (AW=4, WAIT_SHIFT=8, CW=16).
//   Expected {addr,dout} pairs are queued when write commands are pushed and
//   compared whenever the DUT drives wr_n low; timing is checked from the
//   clk cycle numbers at which pushes and write pulses occur.
module tb_jt49_cmdseq;
    import jt49_cmdseq_pkg::*;

    localparam int AW         = 4;
    localparam int WAIT_SHIFT = 8;
    localparam int CW         = 16;
    localparam int DEPTH      = 2 ** AW;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen   = 1'b0;
    logic        push  = 1'b0;
    logic [11:0] cmd   = '0;
    logic        flush = 1'b0;
    logic        full;
    logic [AW:0] level;
    logic        ovf;
    logic        busy;
    logic        done;
    logic [3:0]  addr;
    logic [7:0]  dout;
    logic        wr_n;
    logic        cs_n;
`ifdef JT49_CMDSEQ_WRCNT_EN
    logic [15:0] wrcnt;
`endif

    jt49_cmdseq #(.AW(AW), .WAIT_SHIFT(WAIT_SHIFT), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .push  (push),
        .cmd   (cmd),
        .flush (flush),
        .full  (full),
        .level (level),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done),
        .addr  (addr),
        .dout  (dout),
        .wr_n  (wr_n),
        .cs_n  (cs_n)
`ifdef JT49_CMDSEQ_WRCNT_EN
        ,
        .wrcnt (wrcnt)
`endif
    );

    // ---------------- clock / reset / cen ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // cen_div: 0 = cen held low, N = one cen pulse every N clks.
    int cen_div = 1;
    int cen_ph  = 0;
    always @(negedge clk) begin
        if (cen_div == 0) begin
            cen    = 1'b0;
            cen_ph = 0;
        end else begin
            cen    = (cen_ph == 0);
            cen_ph = (cen_ph + 1) % cen_div;
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [11:0] exp_q[$];
    int          wr_cyc_q[$];
    int          n_wr     = 0;
    bit          prev_low = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (!wr_n) begin
                logic [11:0] e;
                n_wr++;
                wr_cyc_q.push_back(cyc);
                check("wr_pulse_width_1clk", 32'(prev_low), 32'd0);
                check("cs_n_with_wr_n", 32'(cs_n), 32'd0);
                check("write_was_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr_dout", {20'd0, addr, dout}, {20'd0, e});
                end
            end
            prev_low = !wr_n;
        end else begin
            prev_low = 0;
        end
    end

    // ---------------- driver tasks ----------------
    int last_push_cyc = 0;

    // Called just after a falling clk edge; leaves at the next falling edge.
    task automatic push_word(input logic [11:0] c, input bit expect_wr);
        push = 1'b1;
        cmd  = c;
        last_push_cyc = cyc + 1;
        if (expect_wr && c[11:8] <= 4'hD) exp_q.push_back(c);
        @(negedge clk);
        push = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_writes(input string tag, input int target, input int budget);
        int n = 0;
        while (n_wr < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n_wr >= target), 32'd1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int p0;
        int nw;

        repeat (3) @(negedge clk);
        // Reset state
        check("rst_level", 32'(level), 32'd0);
        check("rst_flags{full,ovf,busy,done,wr_n,cs_n}",
              {26'd0, full, ovf, busy, done, wr_n, cs_n}, 32'b000011);
        check("rst_addr_dout", {20'd0, addr, dout}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two back-to-back writes: latency and 2-clk issue spacing
        wr_cyc_q.delete();
        nw = n_wr;
        push_word({4'h0, 8'h11}, 1);
        p0 = last_push_cyc;
        push_word({4'h1, 8'h02}, 1);
        wait_writes("t1_two_writes", nw + 2, 40);
        check("t1_nwr", 32'(wr_cyc_q.size()), 32'd2);
        if (wr_cyc_q.size() >= 2) begin
            check("t1_latency_push_to_wr", 32'(wr_cyc_q[0] - p0), 32'd1);
            check("t1_write_spacing", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'd2);
        end
        repeat (2) @(negedge clk);
        check("t1_busy_after", 32'(busy), 32'd0);
`ifdef JT49_CMDSEQ_WRCNT_EN
        check("t1_wrcnt", 32'(wrcnt), 32'(n_wr[15:0]));
`endif

        // Zero-length wait costs one cen tick: write gap = 1 + 1 + 1 + 1 clks
        wr_cyc_q.delete();
        nw = n_wr;
        push_word({4'h2, 8'hA1}, 1);
        push_word({4'hF, 8'h00}, 1);
        push_word({4'h3, 8'hB2}, 1);
        wait_writes("t2_writes", nw + 2, 40);
        if (wr_cyc_q.size() >= 2)
            check("t2_wait0_gap", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'd4);

        // Wait 3 << 8 = 768: push->pop 1, 769 wait ticks, pop of next 1
        wr_cyc_q.delete();
        nw = n_wr;
        push_word({4'hF, 8'h03}, 1);
        p0 = last_push_cyc;
        push_word({4'h7, 8'h31}, 1);
        wait_writes("t3_write_after_wait", nw + 1, 2000);
        if (wr_cyc_q.size() >= 1)
            check("t3_wait768_delay", 32'(wr_cyc_q[0] - p0), 32'((3 << WAIT_SHIFT) + 3));

        // cen 1-in-4: write, wait 257 cen ticks, write; gap = (1+257+1)*4 clks
        cen_div = 4;
        repeat (4) @(negedge clk);
        wr_cyc_q.delete();
        nw = n_wr;
        push_word({4'h2, 8'hAA}, 1);
        push_word({4'hF, 8'h01}, 1);
        push_word({4'h3, 8'hBB}, 1);
        wait_writes("t4_writes", nw + 2, 3000);
        if (wr_cyc_q.size() >= 2)
            check("t4_cen4_wait_gap", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'((1 + 257 + 1) * 4));

        // Fill with cen low: full/level/ovf boundaries, then push+flush
        cen_div = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < DEPTH - 1; i++) push_word({4'h4, 8'(i)}, 0);
        check("t5_level_15", 32'(level), 32'(DEPTH - 1));
        check("t5_not_full_15", 32'(full), 32'd0);
        push_word({4'h4, 8'hF0}, 0);
        check("t5_level_16", 32'(level), 32'(DEPTH));
        check("t5_full_16", 32'(full), 32'd1);
        check("t5_no_ovf_16", 32'(ovf), 32'd0);
        push_word({4'h4, 8'hF1}, 0);
        check("t5_ovf_17", 32'(ovf), 32'd1);
        check("t5_level_17", 32'(level), 32'(DEPTH));
        flush = 1'b1;
        push  = 1'b1;
        cmd   = {4'h4, 8'hF2};
        @(negedge clk);
        flush = 1'b0;
        push  = 1'b0;
        check("t5_flush_level", 32'(level), 32'd0);
        check("t5_flush_ovf", 32'(ovf), 32'd0);
        check("t5_flush_full", 32'(full), 32'd0);

        // End-of-stream: no further pops, contents retained
        cen_div = 1;
        nw = n_wr;
        push_word({4'hE, 8'h00}, 0);
        push_word({4'h8, 8'h10}, 0);
        repeat (10) @(negedge clk);
        check("t6_done", 32'(done), 32'd1);
        check("t6_level_retained", 32'(level), 32'd1);
        check("t6_busy", 32'(busy), 32'd1);
        check("t6_no_write", 32'(n_wr), 32'(nw));
        do_flush();
        check("t6_flush_done", 32'(done), 32'd0);
        check("t6_flush_level", 32'(level), 32'd0);
        check("t6_flush_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a long wait
        nw = n_wr;
        push_word({4'hF, 8'h02}, 0);
        push_word({4'h5, 8'h55}, 0);
        repeat (12) @(negedge clk);
        check("t7_busy_before_rst", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_level", 32'(level), 32'd0);
        check("t7_rst_flags{full,ovf,busy,done,wr_n,cs_n}",
              {26'd0, full, ovf, busy, done, wr_n, cs_n}, 32'b000011);
        check("t7_rst_addr_dout", {20'd0, addr, dout}, 32'd0);
`ifdef JT49_CMDSEQ_WRCNT_EN
        check("t7_rst_wrcnt", 32'(wrcnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t7_busy_after_rst", 32'(busy), 32'd0);
        check("t7_level_after_rst", 32'(level), 32'd0);
        check("t7_no_write_after_rst", 32'(n_wr), 32'(nw));

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
